tas_gate_ctrl: RTL and testbench

Time-aware gate controller (802.1Qbv-style) for the egress output scheduler. It sequences a gate control list (GCL) that holds per-queue open/close masks and per-entry durations. It drives a 4-bit gate vector that eos uses to qualify queue eligibility. The GCL is double-buffered: lcm writes the admin bank while the oper bank runs, and the banks swap only at a GCL cycle boundary.

---
 rtl/tas_gate_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_tas_gate_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tas_gate_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tas_gate_ctrl: time-aware gate controller with a double-buffered GCL  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tas_gate_ctrl #(
  parameter int NQ        = 4,
  parameter int GCL_DEPTH = 8,
  parameter int GCL_AW    = 3,
  parameter int INTV_W    = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr_i,
  input  logic [GCL_AW-1:0]    cfg_addr_i,
  input  logic [NQ+INTV_W-1:0] cfg_wdata_i,
  input  logic [GCL_AW:0]      cfg_len_i,
  input  logic                 cfg_commit_i,
  input  logic                 cfg_enable_i,
  output logic                 cfg_busy_o,
  output logic                 commit_done_o,
  output logic [NQ-1:0]        gate_open_o,
  output logic [GCL_AW-1:0]    slot_idx_o,
  output logic                 cycle_start_o,
  output logic [15:0]          cycle_cnt_o
);

  localparam int ENT_W = NQ + INTV_W;
  localparam int LEN_W = GCL_AW + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 oper_sel_q, oper_sel_d;
  logic [LEN_W-1:0]     oper_len_q, oper_len_d;
  logic [LEN_W-1:0]     admin_len_q, admin_len_d;
  logic                 busy_q, busy_d;
  logic                 commit_done_q, commit_done_d;
  logic                 cycle_start_q, cycle_start_d;
  logic [GCL_AW-1:0]    slot_q, slot_d;
  logic [INTV_W-1:0]    cnt_q, cnt_d;
  logic [NQ-1:0]        gate_q, gate_d;
  logic [15:0]          cycle_cnt_q, cycle_cnt_d;
  logic [ENT_W-1:0]     bank_q [2][GCL_DEPTH];

  logic                 commit_req;
  logic [LEN_W-1:0]     len_clamped;
  logic                 last_slot;
  logic [GCL_AW-1:0]    slot_inc;
  logic [ENT_W-1:0]     ent_next;
  logic [ENT_W-1:0]     ent0_cur;
  logic [ENT_W-1:0]     ent0_alt;
  logic                 ld_en;
  logic [ENT_W-1:0]     ld_ent;

  function automatic logic [NQ-1:0] ent_mask(input logic [ENT_W-1:0] e);
    return e[ENT_W-1 -: NQ];
  endfunction

  // A zero interval still occupies one cycle, so the counter starts at max(iv,1)-1.
  function automatic logic [INTV_W-1:0] ent_cnt(input logic [ENT_W-1:0] e);
    logic [INTV_W-1:0] iv;
    iv = e[INTV_W-1:0];
    return (iv == '0) ? '0 : (iv - INTV_W'(1));
  endfunction

  assign commit_req  = cfg_commit_i & ~busy_q;
  assign len_clamped = (cfg_len_i > LEN_W'(GCL_DEPTH)) ? LEN_W'(GCL_DEPTH) : cfg_len_i;
  assign last_slot   = (LEN_W'(slot_q) == (oper_len_q - LEN_W'(1)));
  assign slot_inc    = slot_q + GCL_AW'(1);
  assign ent_next    = bank_q[oper_sel_q][slot_inc];
  assign ent0_cur    = bank_q[oper_sel_q][0];
  assign ent0_alt    = bank_q[~oper_sel_q][0];

  always_comb begin
    state_d       = state_q;
    oper_sel_d    = oper_sel_q;
    oper_len_d    = oper_len_q;
    admin_len_d   = admin_len_q;
    busy_d        = busy_q;
    slot_d        = slot_q;
    cnt_d         = cnt_q;
    gate_d        = gate_q;
    cycle_cnt_d   = cycle_cnt_q;
    commit_done_d = 1'b0;
    cycle_start_d = 1'b0;
    ld_en         = 1'b0;
    ld_ent        = '0;

    if (commit_req) begin
      admin_len_d = len_clamped;
    end

    unique case (state_q)
      S_IDLE: begin
        gate_d = '1;
        if (commit_req) begin
          oper_sel_d    = ~oper_sel_q;
          oper_len_d    = len_clamped;
          commit_done_d = 1'b1;
        end
        // A same-cycle commit swaps first, so entry 0 comes from the new bank.
        if (cfg_enable_i && (oper_len_d != '0)) begin
          state_d       = S_RUN;
          slot_d        = '0;
          ld_en         = 1'b1;
          ld_ent        = commit_req ? ent0_alt : ent0_cur;
          cycle_start_d = 1'b1;
        end
      end

      S_RUN: begin
        if (!cfg_enable_i) begin
          state_d = S_IDLE;
          gate_d  = '1;
          slot_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          if (busy_q) begin
            oper_sel_d    = ~oper_sel_q;
            oper_len_d    = admin_len_q;
            commit_done_d = 1'b1;
          end else if (commit_req) begin
            oper_sel_d    = ~oper_sel_q;
            oper_len_d    = len_clamped;
            commit_done_d = 1'b1;
          end
        end else begin
          if (commit_req) begin
            busy_d = 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - INTV_W'(1);
          end else if (!last_slot) begin
            slot_d = slot_inc;
            ld_en  = 1'b1;
            ld_ent = ent_next;
          end else begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
            slot_d      = '0;
            if (busy_q) begin
              oper_sel_d    = ~oper_sel_q;
              oper_len_d    = admin_len_q;
              busy_d        = 1'b0;
              commit_done_d = 1'b1;
              if (admin_len_q == '0) begin
                state_d = S_IDLE;
                gate_d  = '1;
                cnt_d   = '0;
              end else begin
                ld_en         = 1'b1;
                ld_ent        = ent0_alt;
                cycle_start_d = 1'b1;
              end
            end else begin
              ld_en         = 1'b1;
              ld_ent        = ent0_cur;
              cycle_start_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        gate_d  = '1;
      end
    endcase

    if (ld_en) begin
      gate_d = ent_mask(ld_ent);
      cnt_d  = ent_cnt(ld_ent);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      oper_sel_q    <= 1'b0;
      oper_len_q    <= '0;
      admin_len_q   <= '0;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
      cycle_start_q <= 1'b0;
      slot_q        <= '0;
      cnt_q         <= '0;
      gate_q        <= '1;
      cycle_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      oper_sel_q    <= oper_sel_d;
      oper_len_q    <= oper_len_d;
      admin_len_q   <= admin_len_d;
      busy_q        <= busy_d;
      commit_done_q <= commit_done_d;
      cycle_start_q <= cycle_start_d;
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      gate_q        <= gate_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  // Admin writes land in the non-oper bank and are dropped while a commit is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < GCL_DEPTH; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (cfg_wr_i && !busy_q) begin
      bank_q[~oper_sel_q][cfg_addr_i] <= cfg_wdata_i;
    end
  end

  assign cfg_busy_o    = busy_q;
  assign commit_done_o = commit_done_q;
  assign gate_open_o   = gate_q;
  assign slot_idx_o    = slot_q;
  assign cycle_start_o = cycle_start_q;
  assign cycle_cnt_o   = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tas_gate_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tas_gate_ctrl: vector table + scoreboard bench for tas_gate_ctrl   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tas_gate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [23:0] cfg_wdata;
  logic [3:0]  cfg_len;
  logic        cfg_commit;
  logic        cfg_enable;
  logic        cfg_busy;
  logic        commit_done;
  logic [3:0]  gate_open;
  logic [2:0]  slot_idx;
  logic        cycle_start;
  logic [15:0] cycle_cnt;

  tas_gate_ctrl #(
    .NQ(4), .GCL_DEPTH(8), .GCL_AW(3), .INTV_W(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_wr_i(cfg_wr),
    .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata),
    .cfg_len_i(cfg_len),
    .cfg_commit_i(cfg_commit),
    .cfg_enable_i(cfg_enable),
    .cfg_busy_o(cfg_busy),
    .commit_done_o(commit_done),
    .gate_open_o(gate_open),
    .slot_idx_o(slot_idx),
    .cycle_start_o(cycle_start),
    .cycle_cnt_o(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {gate[3:0], slot[2:0], cycle_start, commit_done, busy, cycle_cnt[15:0]}
  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [23:0] wdata;
    logic [3:0]  len;
    logic        commit;
    logic        en;
    logic [25:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [25:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void add(input int wr, input int addr, input int m, input int iv,
                              input int len, input int cm, input int en,
                              input int eg, input int es, input int ecs, input int ecd,
                              input int eb, input int ecyc);
    vec_t v;
    v.wr     = wr[0];
    v.addr   = addr[2:0];
    v.wdata  = {m[3:0], iv[19:0]};
    v.len    = len[3:0];
    v.commit = cm[0];
    v.en     = en[0];
    v.exp    = {eg[3:0], es[2:0], ecs[0], ecd[0], eb[0], ecyc[15:0]};
    vecs.push_back(v);
  endfunction

  function automatic logic [25:0] actual();
    return {gate_open, slot_idx, cycle_start, commit_done, cfg_busy, cycle_cnt};
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gate=%b slot=%0d cs=%b cd=%b busy=%b cyc=%0d, want gate=%b slot=%0d cs=%b cd=%b busy=%b cyc=%0d",
               name, act[25:22], act[21:19], act[18], act[17], act[16], act[15:0],
               exp[25:22], exp[21:19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic build();
    int p;
    // enable with an empty oper list: gates stay open, no cycle start
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0,1, 'hF,0,0,0,0,0);
    // load {0001,3},{1110,2}, commit len=2 in IDLE
    add(1,0,'h1,3,0,0,0, 'hF,0,0,0,0,0);
    add(1,1,'hE,2,0,0,0, 'hF,0,0,0,0,0);
    add(0,0,0,0,2,1,0,   'hF,0,0,1,0,0);
    add(0,0,0,0,0,0,0,   'hF,0,0,0,0,0);
    // run: 0001 x3, 1110 x2, period 5
    for (int k = 0; k < 12; k++) begin
      p = k % 5;
      add(0,0,0,0,0,0,1, (p < 3) ? 'h1 : 'hE, (p < 3) ? 0 : 1, int'(p == 0), 0, 0, k / 5);
    end
    // disable mid-entry, then re-enable from slot 0
    add(0,0,0,0,0,0,0, 'hF,0,0,0,0,2);
    add(0,0,0,0,0,0,0, 'hF,0,0,0,0,2);
    for (int k = 0; k < 4; k++) begin
      p = k % 5;
      add(0,0,0,0,0,0,1, (p < 3) ? 'h1 : 'hE, (p < 3) ? 0 : 1, int'(p == 0), 0, 0, 2 + k / 5);
    end
    // mid-run commit of {1000,4} len=1; write while busy is dropped
    add(1,0,'h8,4,0,0,1, 'hE,1,0,0,0,2);
    add(0,0,0,0,0,0,1,   'h1,0,1,0,0,3);
    add(0,0,0,0,1,1,1,   'h1,0,0,0,1,3);
    add(1,0,'h3,9,0,0,1, 'h1,0,0,0,1,3);
    add(0,0,0,0,0,0,1,   'hE,1,0,0,1,3);
    add(0,0,0,0,0,0,1,   'hE,1,0,0,1,3);
    add(0,0,0,0,0,0,1,   'h8,0,1,1,0,4);
    for (int j = 1; j <= 8; j++) add(0,0,0,0,0,0,1, 'h8,0,int'(j % 4 == 0),0,0, 4 + j / 4);
    // zero-interval entry; commit and enable in the same cycle
    add(0,0,0,0,0,0,0,   'hF,0,0,0,0,6);
    add(1,0,'h4,0,0,0,0, 'hF,0,0,0,0,6);
    add(1,1,'h2,2,0,0,0, 'hF,0,0,0,0,6);
    add(0,0,0,0,2,1,1,   'h4,0,1,1,0,6);
    for (int k = 1; k <= 6; k++) begin
      p = k % 3;
      add(0,0,0,0,0,0,1, (p == 0) ? 'h4 : 'h2, (p == 0) ? 0 : 1, int'(p == 0), 0, 0, 6 + k / 3);
    end
    // cfg_len=12 clamps to 8: one-cycle entries with masks 1..8
    add(0,0,0,0,0,0,0, 'hF,0,0,0,0,8);
    for (int i = 0; i < 8; i++) add(1,i,i+1,0,0,0,0, 'hF,0,0,0,0,8);
    add(0,0,0,0,12,1,0, 'hF,0,0,1,0,8);
    for (int k = 0; k < 18; k++) add(0,0,0,0,0,0,1, (k % 8) + 1, k % 8, int'(k % 8 == 0), 0, 0, 8 + k / 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] exp;
    rst_n      = 1'b0;
    cfg_wr     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    cfg_len    = '0;
    cfg_commit = 1'b0;
    cfg_enable = 1'b0;
    build();

    repeat (2) @(posedge clk);
    #1;
    check("reset", actual(), {4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      cfg_wr     = vecs[i].wr;
      cfg_addr   = vecs[i].addr;
      cfg_wdata  = vecs[i].wdata;
      cfg_len    = vecs[i].len;
      cfg_commit = vecs[i].commit;
      cfg_enable = vecs[i].en;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      check($sformatf("vec[%0d]", i), actual(), exp);
    end

    // asynchronous reset while running, between clock edges
    @(negedge clk);
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", actual(), {4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_len0", actual(), {4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
